// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FSM sequencing the shared-resource multicycle MIPS datapath
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    logic [3:0] cur_state;
    logic [3:0] nxt_state;

    assign state = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: nxt_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt_state = S_ALUWB;
            S_ADDIEX: nxt_state = S_ADDIWB;
            default:  nxt_state = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                instr_done  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSource   = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset holds every control quiet, memory requests included.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            illegal_op  = 1'b0;
            instr_done  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       illegal_op, instr_done;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] act_out();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_done};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Control word each state must present, straight from the per-state table.
    function automatic logic [18:0] exp_out(input int st, input logic mr, input logic [5:0] op);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, sa = 0, ill = 0, dn = 0;
        logic [1:0] sb = 0, aop = 0, pcs = 0;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  begin sb = 2'b11; if (!is_legal(op)) begin ill = 1; dn = 1; end end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; dn = 1; end
            5:  begin mwr = 1; iord = 1; dn = mr; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; dn = 1; end
            8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcwc = 1; dn = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; dn = 1; end
            11: begin pcs = 2'b10; pcw = 1; dn = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, ill, dn};
    endfunction

    function automatic int base_cycles(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Runs one instruction from FETCH to retire; entered just after a rising edge.
    task automatic run_instr(input logic [5:0] op, input bit rnd, input int fs, input int ms,
                             output int cycles, output int irw_n, output int rw_n, output int mw_n);
        int seq[$];
        int idx = 0, waits = 0, done_n = 0, fs_left = fs, ms_left = ms, st;
        bit waitable;
        logic mr;
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 11};
            default:   seq = '{0, 1};
        endcase
        cycles = 0; irw_n = 0; rw_n = 0; mw_n = 0;
        Opcode = op;
        while (idx < seq.size() && cycles < 100) begin
            st = seq[idx];
            waitable = (st == 0 || st == 3 || st == 5);
            if (!waitable) mr = 1'($urandom_range(0, 1));
            else if (rnd) mr = 1'($urandom_range(0, 1));
            else if (st == 0) begin mr = (fs_left == 0); if (fs_left > 0) fs_left--; end
            else begin mr = (ms_left == 0); if (ms_left > 0) ms_left--; end
            mem_ready = mr;
            @(negedge clk);
            n_checks++;
            if (state !== 4'(st)) begin
                n_fail++;
                $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, cycles, state, st);
            end
            n_checks++;
            if (act_out() !== exp_out(st, mr, op)) begin
                n_fail++;
                $display("FAIL outputs op=%b st=%0d mr=%b got=%h want=%h", op, st, mr,
                         act_out(), exp_out(st, mr, op));
            end
            done_n += int'(instr_done);
            irw_n  += int'(IRWrite);
            rw_n   += int'(RegWrite);
            mw_n   += int'(MemWrite);
            if (!waitable || mr) idx++;
            else waits++;
            cycles++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (done_n != 1) begin
            n_fail++;
            $display("FAIL instr_done_count op=%b got=%0d want=1", op, done_n);
        end
        n_checks++;
        if (cycles != base_cycles(op) + waits) begin
            n_fail++;
            $display("FAIL cycle_count op=%b got=%0d want=%0d", op, cycles, base_cycles(op) + waits);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; Opcode = 6'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || act_out() !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state got_state=%0d got_out=%h want_state=0 want_out=0", state, act_out());
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        int c, irw, rw, mw;
        run_instr(6'b000000, 1'b0, 0, 0, c, irw, rw, mw);
        n_checks++;
        if (c != 4 || rw != 1) begin
            n_fail++;
            $display("FAIL rtype cycles=%0d regwrites=%0d want 4 and 1", c, rw);
        end
    endtask

    task automatic test_lw_stall();
        int c, irw, rw, mw;
        run_instr(6'b100011, 1'b0, 2, 1, c, irw, rw, mw);
        n_checks++;
        if (c != 8 || irw != 1) begin
            n_fail++;
            $display("FAIL lw_stall cycles=%0d irwrites=%0d want 8 and 1", c, irw);
        end
    endtask

    task automatic test_sw();
        int c, irw, rw, mw;
        run_instr(6'b101011, 1'b0, 0, 0, c, irw, rw, mw);
        n_checks++;
        if (c != 4 || rw != 0 || mw != 1) begin
            n_fail++;
            $display("FAIL sw cycles=%0d regwrites=%0d memwrites=%0d want 4,0,1", c, rw, mw);
        end
    endtask

    task automatic test_beq_j();
        int c1, c2, irw, rw, mw;
        run_instr(6'b000100, 1'b0, 0, 0, c1, irw, rw, mw);
        run_instr(6'b000010, 1'b0, 0, 0, c2, irw, rw, mw);
        n_checks++;
        if (c1 != 3 || c2 != 3) begin
            n_fail++;
            $display("FAIL beq_j cycles=%0d,%0d want 3,3", c1, c2);
        end
    endtask

    task automatic test_illegal();
        int c, irw, rw, mw;
        run_instr(6'b111111, 1'b0, 0, 0, c, irw, rw, mw);
        n_checks++;
        if (c != 2 || rw != 0 || mw != 0) begin
            n_fail++;
            $display("FAIL illegal cycles=%0d regwrites=%0d memwrites=%0d want 2,0,0", c, rw, mw);
        end
    endtask

    task automatic test_mid_reset();
        Opcode = 6'b100011; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd3 || MemRead !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_memrd state=%0d memread=%b want 3,1", state, MemRead);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || MemRead !== 1'b0 || act_out() !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset state=%0d out=%h want 0,0", state, act_out());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || act_out() !== exp_out(0, 1'b0, Opcode)) begin
            n_fail++;
            $display("FAIL resume_fetch state=%0d out=%h want 0,%h", state, act_out(), exp_out(0, 1'b0, Opcode));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] ops[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b001000, 6'b000010, 6'b111111, 6'b010101};
        logic [5:0] op;
        int c, irw, rw, mw;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'b010101) op = 6'($urandom);
            run_instr(op, 1'b1, 0, 0, c, irw, rw, mw);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_beq_j();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
